stage_wb_regfile: RTL and testbench
===================================

// Module: stage_wb_regfile
// PURPOSE
//  Consumer end of the MA/WB pipeline register: selects the writeback value, commits it to
//  the 32x32 integer register file, and serves the decode stage's two read ports.
//  Sits after stage_mawb; its read outputs feed the ID/EX register.
//  Same-cycle write-to-read bypass, so decode never needs a WB-hazard stall.
// PARAMETERS
//  XLEN      32   datapath width
//  NREGS     32   architectural registers; x0 hardwired to zero
//  CNT_W     32   width of the committed-write counter
// PORTS
//  clk        in   1      system clock; all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  ena_wb     in   1      writeback enable; low = stall, no commit, no count
//  write_ena  in   1      register write request from MA/WB
//  rd         in   5      destination register index
//  wrn        in   2      writeback source select (see BEHAVIOUR)
//  busc       in   XLEN   ALU result
//  data       in   XLEN   load data from memory
//  pc_link    in   XLEN   PC+4 for jal/jalr
//  rs1, rs2   in   5      read addresses from decode
//  bus_a      out  XLEN   read data for rs1
//  bus_b      out  XLEN   read data for rs2
//  wb_value   out  XLEN   selected writeback value, combinational (for forwarding)
//  wb_commit  out  1      high when a write commits this cycle
//  wb_count   out  CNT_W  number of committed writes since reset
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high.
//  - Source select wrn: 00 = busc, 01 = data, 10 = pc_link, 11 = reserved (no write).
//  - wb_value reflects the wrn mux every cycle. For wrn = 11 it is zero.
//  - Commit condition:
//      wb_commit = ena_wb & write_ena & (rd != 0) & (wrn != 11) & ~rst
//  - On posedge with wb_commit high: regs[rd] <= wb_value and wb_count <= wb_count + 1.
//    Visible via storage from the next cycle.
//  - wb_count wraps modulo 2^CNT_W with no saturation or flag.
//  - Reads are combinational: bus_a = (rs1 == 0) ? 0 : (wb_commit && rd == rs1) ? wb_value : regs[rs1].
//    bus_b is identical using rs2.
//  - rs1 == rs2 == rd: both ports are bypassed. x0 reads 0 even when rd == 0 is requested.
//  - Reset: on posedge with rst high, regs[1..31] <= 0 and wb_count <= 0.
//    Writes in that cycle are dropped, including a simultaneous commit request.
//    wb_commit is 0 while rst is high.
//  - Reset mid-stall: reset wins over ena_wb low, and state clears regardless.
//  - Stall (ena_wb low): storage and wb_count hold. Reads still operate with no bypass.
//    A stalled MA/WB holding the same instruction is therefore not double-committed or
//    double-counted.
//  - No X propagation: an uninitialised register is impossible after the first reset cycle.
// STRUCTURE
//  - riscv_pkg holds XLEN, the WB_SEL_ALU/MEM/LINK/NONE 2-bit constants and REG_ZERO = 5'd0.
//    Decode uses the same constants to generate wrn.
//  - Sub-module regfile_array: 31 x XLEN storage with one synchronous write port, sync clear,
//    and two async read ports. x0 is not stored.
//  - Top level holds the wrn mux, commit logic, bypass muxes and wb_count.
// TESTING
//  1. Reset: rst=1 for 1 cycle, then read all 32 regs -> all 0; wb_count=0; wb_commit=0 during reset.
//  2. ALU writeback: wrn=00, rd=5, busc=32'hDEADBEEF, write_ena=1, ena_wb=1 -> next cycle
//     rs1=5 gives bus_a=DEADBEEF and wb_count=1.
//  3. Bypass and sources:
//     - Same cycle, wrn=01, rd=7, data=32'h12345678, rs1=rs2=7 -> bus_a=bus_b=12345678
//       before the edge.
//     - wrn=10, pc_link=32'h104 to rd=1 -> x1=0x104.
//  4. x0 and reserved: rd=0 with busc=FFFFFFFF, and wrn=11 to rd=3 -> x0 reads 0, x3 unchanged,
//     wb_commit=0, wb_count unchanged.
//  5. Stall: ena_wb=0 for 3 cycles with write_ena=1, rd=9 -> x9 unchanged, wb_count unchanged;
//     raise ena_wb -> single commit, count +1.
//  6. Reset collision and wrap:
//     - rst=1 with a simultaneous commit to rd=4 -> x4=0, count=0.
//     - Force wb_count=FFFFFFFF, then commit -> wb_count=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 constants: datapath width, register count and writeback source encodings.
// Decode uses the same WB_SEL_* values when it generates wrn.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int CNT_W = 32;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;
    localparam logic [1:0] WB_SEL_NONE = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_array.sv
// Integer register storage x1..x(NREGS-1): one synchronous write port, synchronous clear,
// two asynchronous read ports. x0 has no storage and always reads zero.
module regfile_array
    import riscv_pkg::*;
#(
    parameter int W  = XLEN,
    parameter int NR = NREGS,
    parameter int AW = $clog2(NR)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [W-1:0]  rdata_a,
    output logic [W-1:0]  rdata_b
);

    logic [W-1:0] regs [1:NR-1];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 1; i < NR; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/stage_wb_regfile.sv
// Writeback stage: picks the writeback source, commits it to the register file, counts
// commits, and serves decode's two read ports with same-cycle write-to-read bypass.
module stage_wb_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN_P  = XLEN,
    parameter int NREGS_P = NREGS,
    parameter int CNT_W_P = CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena_wb,
    input  logic               write_ena,
    input  logic [4:0]         rd,
    input  logic [1:0]         wrn,
    input  logic [XLEN_P-1:0]  busc,
    input  logic [XLEN_P-1:0]  data,
    input  logic [XLEN_P-1:0]  pc_link,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    output logic [XLEN_P-1:0]  bus_a,
    output logic [XLEN_P-1:0]  bus_b,
    output logic [XLEN_P-1:0]  wb_value,
    output logic               wb_commit,
    output logic [CNT_W_P-1:0] wb_count
);

    logic [XLEN_P-1:0]  store_a;
    logic [XLEN_P-1:0]  store_b;
    logic [CNT_W_P-1:0] count_q;

    always_comb begin
        wb_value = '0;
        case (wrn)
            WB_SEL_ALU:  wb_value = busc;
            WB_SEL_MEM:  wb_value = data;
            WB_SEL_LINK: wb_value = pc_link;
            default:     wb_value = '0;
        endcase
    end

    // Reset and stall both suppress the commit, so a held MA/WB entry is written only once.
    assign wb_commit = ena_wb & write_ena & (rd != REG_ZERO) & (wrn != WB_SEL_NONE) & ~rst;

    regfile_array #(
        .W  (XLEN_P),
        .NR (NREGS_P),
        .AW (5)
    ) u_array (
        .clk     (clk),
        .clr     (rst),
        .we      (wb_commit),
        .waddr   (rd),
        .wdata   (wb_value),
        .raddr_a (rs1),
        .raddr_b (rs2),
        .rdata_a (store_a),
        .rdata_b (store_b)
    );

    assign bus_a = (rs1 == REG_ZERO) ? '0 :
                   (wb_commit && rd == rs1) ? wb_value : store_a;
    assign bus_b = (rs2 == REG_ZERO) ? '0 :
                   (wb_commit && rd == rs2) ? wb_value : store_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (wb_commit) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign wb_count = count_q;

endmodule

// File: tb/tb_stage_wb_regfile.sv
// Scenario bench for stage_wb_regfile; a reference register model feeds a queue of expected
// read values, and a narrow-counter second instance exercises counter wrap.
module tb_stage_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena_wb;
    logic        write_ena;
    logic [4:0]  rd;
    logic [1:0]  wrn;
    logic [31:0] busc;
    logic [31:0] data;
    logic [31:0] pc_link;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] bus_a;
    logic [31:0] bus_b;
    logic [31:0] wb_value;
    logic        wb_commit;
    logic [31:0] wb_count;

    logic [31:0] bus_a_w;
    logic [31:0] bus_b_w;
    logic [31:0] wb_value_w;
    logic        wb_commit_w;
    logic [2:0]  wb_count_w;

    logic [31:0] model_regs [32];
    logic [31:0] exp_count;
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    stage_wb_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .ena_wb    (ena_wb),
        .write_ena (write_ena),
        .rd        (rd),
        .wrn       (wrn),
        .busc      (busc),
        .data      (data),
        .pc_link   (pc_link),
        .rs1       (rs1),
        .rs2       (rs2),
        .bus_a     (bus_a),
        .bus_b     (bus_b),
        .wb_value  (wb_value),
        .wb_commit (wb_commit),
        .wb_count  (wb_count)
    );

    stage_wb_regfile #(.CNT_W_P(3)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .ena_wb    (ena_wb),
        .write_ena (write_ena),
        .rd        (rd),
        .wrn       (wrn),
        .busc      (busc),
        .data      (data),
        .pc_link   (pc_link),
        .rs1       (rs1),
        .rs2       (rs2),
        .bus_a     (bus_a_w),
        .bus_b     (bus_b_w),
        .wb_value  (wb_value_w),
        .wb_commit (wb_commit_w),
        .wb_count  (wb_count_w)
    );

    task automatic drive_idle();
        rst       = 1'b0;
        ena_wb    = 1'b1;
        write_ena = 1'b0;
        rd        = 5'd0;
        wrn       = 2'b00;
        busc      = 32'h0;
        data      = 32'h0;
        pc_link   = 32'h0;
        rs1       = 5'd0;
        rs2       = 5'd0;
    endtask

    // Commits one ALU write through the model; driven on negedge, committed at the next posedge.
    task automatic write_alu(input logic [4:0] r, input logic [31:0] v);
        @(negedge clk);
        drive_idle();
        write_ena = 1'b1;
        rd        = r;
        wrn       = 2'b00;
        busc      = v;
        if (r != 5'd0) begin
            model_regs[r] = v;
            exp_count = exp_count + 1;
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1; write_ena = 1'b1; rd = 5'd4; busc = 32'h4444_4444;
        @(negedge clk);
        #1;
        checks++;
        if (wb_commit !== 1'b0) $display("[TB] FAIL reset_commit got=%b want=0", wb_commit);
        else passes++;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        exp_count = 32'h0;
        #1;
        checks++;
        if (wb_count !== 32'h0) $display("[TB] FAIL reset_count got=%h want=0", wb_count);
        else passes++;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            exp_q.push_back(model_regs[i]);
            exp_q.push_back(model_regs[31 - i]);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (bus_a !== exp_v) $display("[TB] FAIL reset_read_a x%0d got=%h want=%h", i, bus_a, exp_v);
            else passes++;
            exp_v = exp_q.pop_front();
            checks++;
            if (bus_b !== exp_v) $display("[TB] FAIL reset_read_b x%0d got=%h want=%h", 31 - i, bus_b, exp_v);
            else passes++;
        end
    endtask

    task automatic test_alu_wb();
        @(negedge clk);
        drive_idle();
        write_ena = 1'b1; rd = 5'd5; wrn = 2'b00; busc = 32'hDEAD_BEEF;
        model_regs[5] = 32'hDEAD_BEEF;
        exp_count = exp_count + 1;
        #1;
        checks++;
        if (wb_value !== 32'hDEAD_BEEF) $display("[TB] FAIL alu_wb_value got=%h want=deadbeef", wb_value);
        else passes++;
        checks++;
        if (wb_commit !== 1'b1) $display("[TB] FAIL alu_commit got=%b want=1", wb_commit);
        else passes++;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        rs1 = 5'd5;
        exp_q.push_back(model_regs[5]);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus_a !== exp_v) $display("[TB] FAIL alu_read got=%h want=%h", bus_a, exp_v);
        else passes++;
        checks++;
        if (wb_count !== exp_count) $display("[TB] FAIL alu_count got=%h want=%h", wb_count, exp_count);
        else passes++;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        drive_idle();
        write_ena = 1'b1; rd = 5'd7; wrn = 2'b01; data = 32'h1234_5678;
        busc = 32'hBAD0_0001; pc_link = 32'hBAD0_0002;
        rs1 = 5'd7; rs2 = 5'd7;
        model_regs[7] = 32'h1234_5678;
        exp_count = exp_count + 1;
        exp_q.push_back(32'h1234_5678);
        exp_q.push_back(32'h1234_5678);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus_a !== exp_v) $display("[TB] FAIL bypass_a got=%h want=%h", bus_a, exp_v);
        else passes++;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus_b !== exp_v) $display("[TB] FAIL bypass_b got=%h want=%h", bus_b, exp_v);
        else passes++;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        write_ena = 1'b1; rd = 5'd1; wrn = 2'b10; pc_link = 32'h0000_0104;
        busc = 32'hBAD0_0003; data = 32'hBAD0_0004;
        model_regs[1] = 32'h0000_0104;
        exp_count = exp_count + 1;
        #1;
        checks++;
        if (wb_value !== 32'h0000_0104) $display("[TB] FAIL link_value got=%h want=00000104", wb_value);
        else passes++;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        rs1 = 5'd1; rs2 = 5'd7;
        exp_q.push_back(model_regs[1]);
        exp_q.push_back(model_regs[7]);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus_a !== exp_v) $display("[TB] FAIL link_read x1 got=%h want=%h", bus_a, exp_v);
        else passes++;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus_b !== exp_v) $display("[TB] FAIL mem_read x7 got=%h want=%h", bus_b, exp_v);
        else passes++;
    endtask

    task automatic test_x0_reserved();
        write_alu(5'd3, 32'hAAAA_5555);
        @(negedge clk);
        drive_idle();
        write_ena = 1'b1; rd = 5'd0; wrn = 2'b00; busc = 32'hFFFF_FFFF;
        rs1 = 5'd0; rs2 = 5'd0;
        #1;
        checks++;
        if (wb_commit !== 1'b0) $display("[TB] FAIL x0_commit got=%b want=0", wb_commit);
        else passes++;
        checks++;
        if (bus_a !== 32'h0) $display("[TB] FAIL x0_bypass got=%h want=0", bus_a);
        else passes++;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        write_ena = 1'b1; rd = 5'd3; wrn = 2'b11; busc = 32'h1111_1111;
        data = 32'h2222_2222; pc_link = 32'h3333_3333;
        rs1 = 5'd3;
        exp_q.push_back(model_regs[3]);
        #1;
        checks++;
        if (wb_value !== 32'h0) $display("[TB] FAIL reserved_value got=%h want=0", wb_value);
        else passes++;
        checks++;
        if (wb_commit !== 1'b0) $display("[TB] FAIL reserved_commit got=%b want=0", wb_commit);
        else passes++;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus_a !== exp_v) $display("[TB] FAIL reserved_nobypass got=%h want=%h", bus_a, exp_v);
        else passes++;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        rs1 = 5'd0; rs2 = 5'd3;
        exp_q.push_back(32'h0);
        exp_q.push_back(model_regs[3]);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus_a !== exp_v) $display("[TB] FAIL x0_read got=%h want=%h", bus_a, exp_v);
        else passes++;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus_b !== exp_v) $display("[TB] FAIL x3_unchanged got=%h want=%h", bus_b, exp_v);
        else passes++;
        checks++;
        if (wb_count !== exp_count) $display("[TB] FAIL x0_reserved_count got=%h want=%h", wb_count, exp_count);
        else passes++;
    endtask

    task automatic test_stall();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive_idle();
            ena_wb = 1'b0; write_ena = 1'b1; rd = 5'd9; wrn = 2'b00; busc = 32'h9999_0009;
            rs1 = 5'd9;
            exp_q.push_back(model_regs[9]);
            #1;
            checks++;
            if (wb_commit !== 1'b0) $display("[TB] FAIL stall_commit cyc%0d got=%b want=0", c, wb_commit);
            else passes++;
            exp_v = exp_q.pop_front();
            checks++;
            if (bus_a !== exp_v) $display("[TB] FAIL stall_read cyc%0d got=%h want=%h", c, bus_a, exp_v);
            else passes++;
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        checks++;
        if (wb_count !== exp_count) $display("[TB] FAIL stall_count got=%h want=%h", wb_count, exp_count);
        else passes++;
        ena_wb = 1'b1;
        model_regs[9] = 32'h9999_0009;
        exp_count = exp_count + 1;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        rs1 = 5'd9;
        exp_q.push_back(model_regs[9]);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus_a !== exp_v) $display("[TB] FAIL stall_release_read got=%h want=%h", bus_a, exp_v);
        else passes++;
        checks++;
        if (wb_count !== exp_count) $display("[TB] FAIL stall_release_count got=%h want=%h", wb_count, exp_count);
        else passes++;
    endtask

    task automatic test_reset_collision();
        write_alu(5'd4, 32'h0000_4444);
        @(negedge clk);
        drive_idle();
        rst = 1'b1; ena_wb = 1'b0; write_ena = 1'b1; rd = 5'd4; busc = 32'h5555_4444;
        #1;
        checks++;
        if (wb_commit !== 1'b0) $display("[TB] FAIL rst_stall_commit got=%b want=0", wb_commit);
        else passes++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; ena_wb = 1'b1;
        #1;
        checks++;
        if (wb_commit !== 1'b0) $display("[TB] FAIL rst_collide_commit got=%b want=0", wb_commit);
        else passes++;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        exp_count = 32'h0;
        rs1 = 5'd4; rs2 = 5'd5;
        exp_q.push_back(model_regs[4]);
        exp_q.push_back(model_regs[5]);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus_a !== exp_v) $display("[TB] FAIL rst_collide_x4 got=%h want=%h", bus_a, exp_v);
        else passes++;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus_b !== exp_v) $display("[TB] FAIL rst_collide_x5 got=%h want=%h", bus_b, exp_v);
        else passes++;
        checks++;
        if (wb_count !== exp_count) $display("[TB] FAIL rst_collide_count got=%h want=%h", wb_count, exp_count);
        else passes++;
    endtask

    task automatic test_wrap();
        for (int k = 1; k <= 8; k++) begin
            write_alu(5'(10 + k), 32'hC0DE_0000 + 32'(k));
            @(negedge clk);
            drive_idle();
            #1;
            checks++;
            if (wb_count_w !== exp_count[2:0])
                $display("[TB] FAIL wrap_count_w n=%0d got=%0d want=%0d", k, wb_count_w, exp_count[2:0]);
            else passes++;
        end
        checks++;
        if (wb_count !== exp_count) $display("[TB] FAIL wrap_count_full got=%h want=%h", wb_count, exp_count);
        else passes++;
        rs1 = 5'd18;
        exp_q.push_back(model_regs[18]);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus_a !== exp_v) $display("[TB] FAIL wrap_read_x18 got=%h want=%h", bus_a, exp_v);
        else passes++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        exp_count = 32'h0;
        drive_idle();
        test_reset();
        test_alu_wb();
        test_bypass();
        test_x0_reserved();
        test_stall();
        test_reset_collision();
        test_wrap();
        checks++;
        if (exp_q.size() != 0) $display("[TB] FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
